// File: rtl/sram_arbiter.sv
// Two-requester (SNES / AVR) arbiter for a single asynchronous SRAM.
// Each access runs SETUP -> STROBE x ACCESS_CYCLES -> HOLD; SNES has priority, bounded by a streak limit.
module sram_arbiter #(
    parameter int ADDR_W          = 21,
    parameter int ACCESS_CYCLES   = 2,
    parameter int MAX_SNES_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snes_req,
    input  logic              snes_we,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [7:0]        snes_wdata,
    output logic              snes_ack,
    output logic [7:0]        snes_rdata,
    input  logic              avr_req,
    input  logic              avr_we,
    input  logic [ADDR_W-1:0] avr_addr,
    input  logic [7:0]        avr_wdata,
    output logic              avr_ack,
    output logic [7:0]        avr_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_dout_en,
    input  logic [7:0]        sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              grant_snes
);

    localparam logic [3:0] AC = 4'(ACCESS_CYCLES);
    localparam logic [3:0] MS = 4'(MAX_SNES_STREAK);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } req_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic [3:0] streak;
    req_t       cur;
    logic       gs_q;
    logic       pick_snes;
    logic       take;

    // SNES wins ties unless it has already starved a waiting AVR for MS grants
    assign pick_snes = snes_req & ~(avr_req & (streak == MS));
    assign take      = snes_req | avr_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == 4'd1) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 cnt <= '0;
        else if (state == SETUP)   cnt <= AC;
        else if (state == STROBE)  cnt <= cnt - 4'd1;
    end

    // Grant decision and request latch; inputs are ignored until back in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur    <= '0;
            gs_q   <= 1'b0;
            streak <= '0;
        end else if (state == IDLE && take) begin
            gs_q <= pick_snes;
            if (pick_snes) begin
                cur <= '{we: snes_we, addr: snes_addr, wdata: snes_wdata};
                if (!avr_req)        streak <= '0;
                else if (streak != MS) streak <= streak + 4'd1;
            end else begin
                cur    <= '{we: avr_we, addr: avr_addr, wdata: avr_wdata};
                streak <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snes_rdata <= '0;
            avr_rdata  <= '0;
        end else if (state == STROBE && cnt == 4'd1 && !cur.we) begin
            if (gs_q) snes_rdata <= sram_din;
            else      avr_rdata  <= sram_din;
        end
    end

    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dout_en = 1'b0;
        snes_ack     = 1'b0;
        avr_ack      = 1'b0;
        busy         = (state != IDLE);
        if (state != IDLE) begin
            sram_ce_n    = 1'b0;
            sram_dout_en = cur.we;
        end
        if (state == STROBE) begin
            sram_oe_n = cur.we;
            sram_we_n = ~cur.we;
        end
        if (state == HOLD) begin
            snes_ack = gs_q;
            avr_ack  = ~gs_q;
        end
    end

    assign sram_addr  = cur.addr;
    assign sram_dout  = cur.wdata;
    assign grant_snes = gs_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus sequences for
// fairness, back-to-back timing and reset abort, against a small SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snes_req = 0, snes_we = 0, avr_req = 0, avr_we = 0;
    logic [20:0] snes_addr = 21'h00010, avr_addr = '0;
    logic [7:0]  snes_wdata = 8'h3C, avr_wdata = '0;
    logic        snes_ack, avr_ack, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n, busy, grant_snes;
    logic [7:0]  snes_rdata, avr_rdata, sram_dout, sram_din;
    logic [20:0] sram_addr;
    logic [7:0]  mem [4096];

    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
        .snes_ack(snes_ack), .snes_rdata(snes_rdata),
        .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
        .avr_ack(avr_ack), .avr_rdata(avr_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy), .grant_snes(grant_snes)
    );

    // Behavioural SRAM: async read, write committed while we_n is low
    assign sram_din = mem[sram_addr[11:0]];
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dout_en) mem[sram_addr[11:0]] <= sram_dout;

    typedef struct {
        logic sr, sw, ar, aw;
        logic [20:0] aa;
        logic [7:0]  ad;
        logic ce, oe, we, den, sack, aack, bsy, gs;
        logic [7:0]  ard, srd;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] order;
        logic [9:0] exp_order;
        int         ng, k, acks;
        int         ack_at [3];

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // sr sw ar aw addr wdata | ce oe we den sack aack busy gs ard srd
        tbl[0]  = '{0,0,1,1,21'h01234,8'h5A, 0,1,1,1,0,0,1,0,8'h00,8'h00};
        tbl[1]  = '{0,0,1,1,21'h01234,8'h5A, 0,1,0,1,0,0,1,0,8'h00,8'h00};
        tbl[2]  = '{0,0,1,1,21'h01234,8'h5A, 0,1,0,1,0,0,1,0,8'h00,8'h00};
        tbl[3]  = '{0,0,1,1,21'h01234,8'h5A, 0,1,1,1,0,1,1,0,8'h00,8'h00};
        tbl[4]  = '{0,0,0,0,21'h01234,8'h00, 1,1,1,0,0,0,0,0,8'h00,8'h00};
        tbl[5]  = '{0,0,1,0,21'h01234,8'h00, 0,1,1,0,0,0,1,0,8'h00,8'h00};
        tbl[6]  = '{0,0,1,0,21'h01234,8'h00, 0,0,1,0,0,0,1,0,8'h00,8'h00};
        tbl[7]  = '{0,0,1,0,21'h01234,8'h00, 0,0,1,0,0,0,1,0,8'h00,8'h00};
        tbl[8]  = '{0,0,1,0,21'h01234,8'h00, 0,1,1,0,0,1,1,0,8'h5A,8'h00};
        tbl[9]  = '{0,0,0,0,21'h01234,8'h00, 1,1,1,0,0,0,0,0,8'h5A,8'h00};
        tbl[10] = '{1,1,0,0,21'h01234,8'h00, 0,1,1,1,0,0,1,1,8'h5A,8'h00};
        tbl[11] = '{1,1,0,0,21'h01234,8'h00, 0,1,0,1,0,0,1,1,8'h5A,8'h00};
        tbl[12] = '{1,1,0,0,21'h01234,8'h00, 0,1,0,1,0,0,1,1,8'h5A,8'h00};
        tbl[13] = '{1,1,0,0,21'h01234,8'h00, 0,1,1,1,1,0,1,1,8'h5A,8'h00};
        tbl[14] = '{0,0,0,0,21'h01234,8'h00, 1,1,1,0,0,0,0,1,8'h5A,8'h00};
        tbl[15] = '{1,0,0,0,21'h01234,8'h00, 0,1,1,0,0,0,1,1,8'h5A,8'h00};
        tbl[16] = '{1,0,0,0,21'h01234,8'h00, 0,0,1,0,0,0,1,1,8'h5A,8'h00};
        tbl[17] = '{1,0,0,0,21'h01234,8'h00, 0,0,1,0,0,0,1,1,8'h5A,8'h00};
        tbl[18] = '{1,0,0,0,21'h01234,8'h00, 0,1,1,0,1,0,1,1,8'h5A,8'h3C};
        tbl[19] = '{0,0,0,0,21'h01234,8'h00, 1,1,1,0,0,0,0,1,8'h5A,8'h3C};

        // Reset state
        #12;
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 4'b1110);
        chk("rst_ctl", {snes_ack, avr_ack, busy, grant_snes}, 4'b0000);
        chk("rst_bus", {sram_addr, sram_dout, snes_rdata, avr_rdata}, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table: AVR write/read, then SNES write/read
        for (int i = 0; i < 20; i++) begin
            snes_req = tbl[i].sr; snes_we = tbl[i].sw;
            avr_req  = tbl[i].ar; avr_we  = tbl[i].aw;
            avr_addr = tbl[i].aa; avr_wdata = tbl[i].ad;
            tick();
            chk($sformatf("row%0d", i),
                {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, snes_ack, avr_ack, busy, grant_snes,
                 avr_rdata, snes_rdata},
                {tbl[i].ce, tbl[i].oe, tbl[i].we, tbl[i].den, tbl[i].sack, tbl[i].aack, tbl[i].bsy,
                 tbl[i].gs, tbl[i].ard, tbl[i].srd});
            if (i == 0) chk("setup_addr", 32'(sram_addr), 32'h01234);
        end

        // Both requesting continuously: streak limit forces every fifth grant to AVR
        snes_req = 1; snes_we = 0; avr_req = 1; avr_we = 0; avr_addr = 21'h01234;
        exp_order = 10'b1111011110;
        ng = 0; k = 0; order = '0;
        while (ng < 10 && k < 200) begin
            tick(); k++;
            if (snes_ack && avr_ack) chk("two_acks", 32'(k), 32'hFFFFFFFF);
            if (snes_ack || avr_ack) begin
                order[9-ng] = snes_ack;
                ng++;
            end
        end
        snes_req = 0; avr_req = 0;
        chk("grant_count", 32'(ng), 32'd10);
        for (int g = 0; g < 10; g++) chk($sformatf("grant%0d", g), 32'(order[9-g]), 32'(exp_order[9-g]));
        tick();

        // Back-to-back SNES reads: ack at edge 4, then every 5 edges
        snes_req = 1; snes_we = 0;
        acks = 0; k = 0;
        while (acks < 3 && k < 40) begin
            tick(); k++;
            if (!sram_oe_n && !sram_we_n) chk("oe_we_both_low", 32'(k), 32'hFFFFFFFF);
            if (snes_ack) begin
                ack_at[acks] = k;
                acks++;
            end
        end
        snes_req = 0;
        chk("b2b_acks", 32'(acks), 32'd3);
        chk("b2b_first", 32'(ack_at[0]), 32'd4);
        chk("b2b_period1", 32'(ack_at[1] - ack_at[0]), 32'd5);
        chk("b2b_period2", 32'(ack_at[2] - ack_at[1]), 32'd5);
        tick();

        // Reset during the second STROBE cycle of a write
        avr_req = 1; avr_we = 1; avr_addr = 21'h00020; avr_wdata = 8'hA5;
        tick(); tick(); tick();
        chk("pre_abort_we", {sram_we_n, sram_ce_n, sram_dout_en}, 3'b001);
        #1 reset = 1'b1;
        #1;
        chk("abort_strobes", {sram_ce_n, sram_we_n, sram_oe_n, sram_dout_en}, 4'b1110);
        chk("abort_state", {busy, avr_ack, snes_ack, grant_snes, avr_rdata, snes_rdata}, '0);
        avr_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (avr_ack || snes_ack) acks++;
        end
        chk("no_ack_after_abort", 32'(acks), 32'd0);

        // Clean access afterwards
        avr_req = 1; avr_we = 0; avr_addr = 21'h01234;
        k = 0;
        while (!avr_ack && k < 20) begin
            tick(); k++;
        end
        avr_req = 0;
        chk("post_reset_latency", 32'(k), 32'd4);
        chk("post_reset_rdata", {avr_rdata, snes_rdata}, {8'h5A, 8'h00});
        tick();
        chk("post_reset_idle", {busy, sram_ce_n}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
